conv_sequencer: RTL and testbench
=================================

CONV_SEQUENCER -- requirements
Module: conv_sequencer

Interface
REQ-001 SHALL have parameter IMG_SIZE, default 256: square input image side in pixels.
REQ-002 SHALL have parameter KER_SIZE, default 3: square kernel side in taps.
REQ-003 SHALL have parameter ADDR_W, default 16: width of all address outputs.
REQ-004 SHALL have parameter MAC_LAT, default 2: MAC pipeline latency in cycles, minimum 1.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic rises on its posedge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1 bit: starts one full-frame convolution.
REQ-008 SHALL have port stall, input, 1 bit: freezes tap generation (memory not ready).
REQ-009 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse at frame completion.
REQ-011 SHALL have port im_addr, output, ADDR_W bits: image read address.
REQ-012 SHALL have port k_addr, output, ADDR_W bits: kernel coefficient address.
REQ-013 SHALL have port tap_valid, acc_clr and last_tap, outputs, 1 bit each: current tap is valid / is first of a pixel / is last of a pixel.
REQ-014 SHALL have port wr_en, output, 1 bit, and filt_addr, output, ADDR_W bits: result write strobe and result address.

Function
REQ-015 SHALL define OUT_SIZE = IMG_SIZE-KER_SIZE+1; output pixel (r,c) has r,c in 0..OUT_SIZE-1, tap (i,j) has i,j in 0..KER_SIZE-1.
REQ-016 SHALL implement FSM IDLE -> RUN -> FLUSH -> DONE -> IDLE.
REQ-017 SHALL leave IDLE on start=1; start SHALL be ignored in all other states.
REQ-018 SHALL present tap (0,0) of pixel (0,0) in the first RUN cycle, i.e. one cycle after start is sampled.
REQ-019 SHALL drive in RUN: im_addr=(r+i)*IMG_SIZE+(c+j); k_addr=i*KER_SIZE+j; acc_clr=(i==0&&j==0); last_tap=(i==j==KER_SIZE-1); tap_valid=!stall.
REQ-020 SHALL advance order j, then i, then c, then r, only in RUN cycles with stall=0; when stall=1, all counters and addresses SHALL hold.
REQ-021 SHALL build im_addr incrementally from a row-base register; no multiplier SHALL be used.
REQ-022 SHALL move to FLUSH after the accepted final tap (r=c=OUT_SIZE-1, i=j=KER_SIZE-1).
REQ-023 SHALL stay in FLUSH exactly MAC_LAT cycles, ignoring stall.
REQ-024 SHALL hold DONE for one cycle with done=1, then return to IDLE.
REQ-025 SHALL assert wr_en exactly MAC_LAT cycles after each accepted last_tap, with filt_addr=r*OUT_SIZE+c of that pixel.
REQ-026 SHALL keep the wr_en/filt_addr delay line advancing every cycle, regardless of stall.
REQ-027 SHALL hold tap_valid, acc_clr, last_tap at 0 outside RUN; im_addr and k_addr SHALL hold their last value.
REQ-028 SHALL give, with no stall, a start-to-done time of OUT_SIZE^2*KER_SIZE^2+MAC_LAT+1 cycles.

Reset
REQ-029 SHALL, while rst_n=0, force state IDLE, all counters 0, and every output 0, including the delay line.
REQ-030 SHALL abort a frame when reset is asserted mid-operation; no wr_en SHALL emerge afterwards.

Structure
REQ-031 SHALL place the FSM state encoding and the derived constant OUT_SIZE in shared package conv_pkg.
REQ-032 SHALL implement the MAC_LAT-deep wr_en/filt_addr delay line as sub-module conv_delay_line.

Verification
All scenarios use IMG_SIZE=5, KER_SIZE=3, MAC_LAT=2 (OUT_SIZE=3, 81 taps); start pulses at cycle 0.
REQ-033 No-stall frame SHALL produce:
- cycle 1: im_addr=0, k_addr=0, acc_clr=1.
- cycle 9: im_addr=12, k_addr=8, last_tap=1.
- cycle 10: im_addr=1.
- cycle 11: wr_en=1, filt_addr=0.
- cycle 84: done=1.
REQ-034 Pixel (1,0), tap (0,0) SHALL give im_addr=5; final tap SHALL give im_addr=24; final wr_en SHALL carry filt_addr=8 at cycle 83.
REQ-035 stall=1 at cycles 3-5 SHALL give tap_valid=0 with im_addr held at 2; done SHALL move to cycle 87.
REQ-036 start=1 during RUN SHALL have no effect; start and stall high together in IDLE SHALL enter RUN holding tap (0,0).
REQ-037 rst_n=0 at cycle 40 SHALL force busy=0 and all outputs 0; no wr_en afterwards; a new start SHALL restart at im_addr=0.
REQ-038 Full 81-tap trace SHALL match a reference model tap-for-tap; exactly 9 wr_en pulses SHALL occur with filt_addr 0..8 in order.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and derived geometry for the convolution address sequencer.
package conv_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int unsigned IMG_SIZE_DEF = 256;
  localparam int unsigned KER_SIZE_DEF = 3;

  // Side of the valid (no padding) output image.
  function automatic int unsigned out_size(input int unsigned img, input int unsigned ker);
    return img - ker + 1;
  endfunction

  localparam int unsigned OUT_SIZE = out_size(IMG_SIZE_DEF, KER_SIZE_DEF);

endpackage

// File: rtl/conv_delay_line.sv
// Fixed-latency shift register carrying the result write strobe and address.
module conv_delay_line
  import conv_pkg::*;
#(
  parameter int unsigned LAT = 2,
  parameter int unsigned W   = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_vld,
  input  logic [W-1:0] in_addr,
  output logic         out_vld,
  output logic [W-1:0] out_addr
);

  logic [LAT-1:0] vld_q;
  logic [W-1:0]   addr_q [LAT];

  // Advances every cycle; stall never reaches this pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int k = 0; k < int'(LAT); k++) addr_q[k] <= '0;
    end else begin
      vld_q[0]  <= in_vld;
      addr_q[0] <= in_addr;
      for (int k = 1; k < int'(LAT); k++) begin
        vld_q[k]  <= vld_q[k-1];
        addr_q[k] <= addr_q[k-1];
      end
    end
  end

  assign out_vld  = vld_q[LAT-1];
  assign out_addr = addr_q[LAT-1];

endmodule

// File: rtl/conv_sequencer.sv
// Walks every kernel tap of every output pixel of a square image and
// schedules the result write once the MAC pipeline has drained.
module conv_sequencer
  import conv_pkg::*;
#(
  parameter int unsigned IMG_SIZE = IMG_SIZE_DEF,
  parameter int unsigned KER_SIZE = KER_SIZE_DEF,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned MAC_LAT  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stall,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] im_addr,
  output logic [ADDR_W-1:0] k_addr,
  output logic              tap_valid,
  output logic              acc_clr,
  output logic              last_tap,
  output logic              wr_en,
  output logic [ADDR_W-1:0] filt_addr
);

  localparam int unsigned OUT_N = out_size(IMG_SIZE, KER_SIZE);
  localparam int unsigned KW    = $clog2(KER_SIZE + 1);
  localparam int unsigned OW    = $clog2(OUT_N + 1);
  localparam int unsigned FW    = $clog2(MAC_LAT + 1);

  state_t            state;
  logic [KW-1:0]     ti, tj;
  logic [OW-1:0]     pr, pc;
  logic [ADDR_W-1:0] pix_base, row_base, pix_idx;
  logic [FW-1:0]     flush_cnt;
  logic              j_end, i_end, c_end, r_end;

  assign tap_valid = (state == S_RUN) && !stall;
  assign j_end     = (tj == KW'(KER_SIZE - 1));
  assign i_end     = (ti == KW'(KER_SIZE - 1));
  assign c_end     = (pc == OW'(OUT_N - 1));
  assign r_end     = (pr == OW'(OUT_N - 1));

  // pix_base = window top-left, row_base = pix_base + i*IMG_SIZE, im_addr = row_base + j.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      ti        <= '0;
      tj        <= '0;
      pr        <= '0;
      pc        <= '0;
      pix_base  <= '0;
      row_base  <= '0;
      pix_idx   <= '0;
      flush_cnt <= '0;
      im_addr   <= '0;
      k_addr    <= '0;
      acc_clr   <= 1'b0;
      last_tap  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_RUN;
            busy     <= 1'b1;
            ti       <= '0;
            tj       <= '0;
            pr       <= '0;
            pc       <= '0;
            pix_base <= '0;
            row_base <= '0;
            pix_idx  <= '0;
            im_addr  <= '0;
            k_addr   <= '0;
            acc_clr  <= 1'b1;
            last_tap <= (KER_SIZE == 1);
          end
        end
        S_RUN: begin
          if (tap_valid) begin
            acc_clr  <= 1'b0;
            last_tap <= 1'b0;
            if (j_end && i_end && c_end && r_end) begin
              state     <= S_FLUSH;
              flush_cnt <= '0;
            end else if (!j_end) begin
              tj       <= tj + KW'(1);
              im_addr  <= im_addr + ADDR_W'(1);
              k_addr   <= k_addr + ADDR_W'(1);
              last_tap <= i_end && ((tj + KW'(1)) == KW'(KER_SIZE - 1));
            end else if (!i_end) begin
              tj       <= '0;
              ti       <= ti + KW'(1);
              row_base <= row_base + ADDR_W'(IMG_SIZE);
              im_addr  <= row_base + ADDR_W'(IMG_SIZE);
              k_addr   <= k_addr + ADDR_W'(1);
            end else begin
              tj       <= '0;
              ti       <= '0;
              k_addr   <= '0;
              pix_idx  <= pix_idx + ADDR_W'(1);
              acc_clr  <= 1'b1;
              last_tap <= (KER_SIZE == 1);
              if (!c_end) begin
                pc       <= pc + OW'(1);
                pix_base <= pix_base + ADDR_W'(1);
                row_base <= pix_base + ADDR_W'(1);
                im_addr  <= pix_base + ADDR_W'(1);
              end else begin
                // From (r, OUT_N-1) to (r+1, 0): +IMG_SIZE-(OUT_N-1) == +KER_SIZE.
                pc       <= '0;
                pr       <= pr + OW'(1);
                pix_base <= pix_base + ADDR_W'(KER_SIZE);
                row_base <= pix_base + ADDR_W'(KER_SIZE);
                im_addr  <= pix_base + ADDR_W'(KER_SIZE);
              end
            end
          end
        end
        S_FLUSH: begin
          if (flush_cnt == FW'(MAC_LAT - 1)) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt + FW'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  conv_delay_line #(
    .LAT (MAC_LAT),
    .W   (ADDR_W)
  ) u_delay (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_vld   (tap_valid && last_tap),
    .in_addr  (pix_idx),
    .out_vld  (wr_en),
    .out_addr (filt_addr)
  );

endmodule

// File: tb/tb_conv_sequencer.sv
// Self-checking bench for conv_sequencer at IMG_SIZE=5, KER_SIZE=3, MAC_LAT=2.
module tb_conv_sequencer;

  localparam int IMG  = 5;
  localparam int KER  = 3;
  localparam int AW   = 16;
  localparam int LAT  = 2;
  localparam int OUT  = IMG - KER + 1;
  localparam int NTAP = OUT * OUT * KER * KER;
  localparam int MAXC = 400;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stall = 1'b0;
  logic          busy, done, tap_valid, acc_clr, last_tap, wr_en;
  logic [AW-1:0] im_addr, k_addr, filt_addr;

  always #5 clk = ~clk;

  conv_sequencer #(
    .IMG_SIZE (IMG),
    .KER_SIZE (KER),
    .ADDR_W   (AW),
    .MAC_LAT  (LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stall     (stall),
    .busy      (busy),
    .done      (done),
    .im_addr   (im_addr),
    .k_addr    (k_addr),
    .tap_valid (tap_valid),
    .acc_clr   (acc_clr),
    .last_tap  (last_tap),
    .wr_en     (wr_en),
    .filt_addr (filt_addr)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Log fields: 0 im, 1 k, 2 clr, 3 last, 4 wr, 5 filt, 6 done, 7 tv
  int lg [8][MAXC];

  typedef struct {
    int run;
    int cyc;
    int fld;
    int val;
  } vec_t;

  vec_t vecs [21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: no stall, 1: stall cycles 3-5, 2: random stall, 3: start+stall in IDLE then random start in RUN
  task automatic run_frame(input int mode, input string tag);
    int idx = 0;
    int cyc = 0;
    int t_last = -1000;
    int wr_cnt = 0;
    int q_due[$];
    int q_addr[$];
    int p, t, r, c, i, j;
    logic e_busy, e_tv, e_clr, e_last, e_wr, e_done;
    int e_im, e_k, e_filt;

    start = 1'b1;
    stall = (mode == 3);
    #1;
    chk({tag, " idle busy"}, 32'(busy), 0);
    while (cyc < MAXC - 1) begin
      step();
      cyc++;
      start = (mode == 3 && idx < NTAP) ? 1'($urandom_range(0, 1)) : 1'b0;
      case (mode)
        1:       stall = (cyc >= 3 && cyc <= 5);
        2:       stall = (idx < NTAP) ? ($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1));
        3:       stall = (cyc <= 2);
        default: stall = 1'b0;
      endcase
      #1;
      p = idx / (KER * KER);
      t = idx % (KER * KER);
      r = p / OUT;
      c = p % OUT;
      i = t / KER;
      j = t % KER;
      if (idx < NTAP) begin
        e_busy = 1'b1;
        e_tv   = !stall;
        e_im   = (r + i) * IMG + (c + j);
        e_k    = i * KER + j;
        e_clr  = (t == 0);
        e_last = (t == KER * KER - 1);
        e_done = 1'b0;
      end else begin
        e_busy = (cyc - t_last) <= LAT + 1;
        e_done = (cyc - t_last) == LAT + 1;
        e_tv   = 1'b0;
        e_clr  = 1'b0;
        e_last = 1'b0;
        e_im   = (IMG - 1) * IMG + (IMG - 1);
        e_k    = KER * KER - 1;
      end
      e_wr   = (q_due.size() > 0) && (q_due[0] == cyc);
      e_filt = e_wr ? q_addr[0] : 0;
      if (e_wr) begin
        void'(q_due.pop_front());
        void'(q_addr.pop_front());
      end
      chk($sformatf("%s ctl c%0d {busy,tv,clr,last,wr,done}", tag, cyc),
          32'({busy, tap_valid, acc_clr, last_tap, wr_en, done}),
          32'({e_busy, e_tv, e_clr, e_last, e_wr, e_done}));
      chk($sformatf("%s im_addr c%0d", tag, cyc), 32'(im_addr), 32'(e_im));
      chk($sformatf("%s k_addr c%0d", tag, cyc), 32'(k_addr), 32'(e_k));
      if (e_wr) chk($sformatf("%s filt_addr c%0d", tag, cyc), 32'(filt_addr), 32'(e_filt));
      lg[0][cyc] = int'(im_addr);
      lg[1][cyc] = int'(k_addr);
      lg[2][cyc] = int'(acc_clr);
      lg[3][cyc] = int'(last_tap);
      lg[4][cyc] = int'(wr_en);
      lg[5][cyc] = int'(filt_addr);
      lg[6][cyc] = int'(done);
      lg[7][cyc] = int'(tap_valid);
      if (wr_en) wr_cnt++;
      if (idx < NTAP && !stall) begin
        if (t == KER * KER - 1) begin
          q_due.push_back(cyc + LAT);
          q_addr.push_back(r * OUT + c);
        end
        idx++;
        if (idx == NTAP) t_last = cyc;
      end
      if (idx == NTAP && cyc >= t_last + LAT + 3) break;
    end
    start = 1'b0;
    stall = 1'b0;
    chk({tag, " taps accepted within budget"}, 32'(idx), 32'(NTAP));
    chk({tag, " wr_en pulse count"}, 32'(wr_cnt), 32'(OUT * OUT));
  endtask

  task automatic check_table(input int run, input string tag);
    for (int v = 0; v < $size(vecs); v++) begin
      if (vecs[v].run == run)
        chk($sformatf("%s vec c%0d f%0d", tag, vecs[v].cyc, vecs[v].fld),
            32'(lg[vecs[v].fld][vecs[v].cyc]), 32'(vecs[v].val));
    end
  endtask

  task automatic reset_mid(input int at);
    start = 1'b1;
    stall = 1'b0;
    step();
    start = 1'b0;
    for (int k = 1; k < at; k++) step();
    rst_n = 1'b0;
    #1;
    chk($sformatf("rst@%0d ctl", at), 32'({busy, done, tap_valid, acc_clr, last_tap, wr_en}), 0);
    chk($sformatf("rst@%0d addrs", at), 32'(im_addr | k_addr | filt_addr), 0);
    step();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      chk($sformatf("rst@%0d quiet +%0d {wr,busy}", at, k), 32'({wr_en, busy}), 0);
    end
  endtask

  initial begin
    vecs[0]  = '{0, 1, 0, 0};
    vecs[1]  = '{0, 1, 1, 0};
    vecs[2]  = '{0, 1, 2, 1};
    vecs[3]  = '{0, 9, 0, 12};
    vecs[4]  = '{0, 9, 1, 8};
    vecs[5]  = '{0, 9, 3, 1};
    vecs[6]  = '{0, 10, 0, 1};
    vecs[7]  = '{0, 11, 4, 1};
    vecs[8]  = '{0, 11, 5, 0};
    vecs[9]  = '{0, 84, 6, 1};
    vecs[10] = '{0, 28, 0, 5};
    vecs[11] = '{0, 81, 0, 24};
    vecs[12] = '{0, 83, 4, 1};
    vecs[13] = '{0, 83, 5, 8};
    vecs[14] = '{1, 3, 7, 0};
    vecs[15] = '{1, 4, 7, 0};
    vecs[16] = '{1, 5, 7, 0};
    vecs[17] = '{1, 3, 0, 2};
    vecs[18] = '{1, 5, 0, 2};
    vecs[19] = '{1, 6, 0, 2};
    vecs[20] = '{1, 87, 6, 1};

    #12;
    chk("reset ctl", 32'({busy, done, tap_valid, acc_clr, last_tap, wr_en}), 0);
    chk("reset addrs", 32'(im_addr | k_addr | filt_addr), 0);
    step();
    rst_n = 1'b1;
    step();

    run_frame(0, "nostall");
    check_table(0, "nostall");
    step();
    run_frame(1, "stall35");
    check_table(1, "stall35");
    run_frame(3, "startstall");
    for (int n = 0; n < 3; n++) run_frame(2, $sformatf("rand%0d", n));
    reset_mid(40);
    run_frame(0, "restart");
    reset_mid(37);
    run_frame(2, "restart_rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
